// File: rtl/result_drain_pkg.sv
// Shared types and constants for the systolic-array result drain.
package result_drain_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  localparam int ROWS      = 8;
  localparam int COLS      = 8;
  localparam int OUT_W_DEF = 16;
  localparam int OUT_MAX   = (1 << (OUT_W_DEF - 1)) - 1;
  localparam int OUT_MIN   = -(1 << (OUT_W_DEF - 1));

endpackage

// File: rtl/requant_sat.sv
// One-element requantizer: rounding arithmetic right shift, then saturation to OUT_WIDTH.
// Combinational. RESULT_DRAIN_RELU_EN zeroes negative results after saturation.
module requant_sat #(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT_W   = 5
) (
  input  logic signed [ACC_WIDTH-1:0] x,
  input  logic        [SHIFT_W-1:0]   s,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        sat
);

  localparam logic signed [ACC_WIDTH:0] HI =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] LO =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  logic signed [ACC_WIDTH:0]   x_ext;
  logic signed [ACC_WIDTH:0]   rnd;
  logic signed [ACC_WIDTH:0]   t;
  logic signed [ACC_WIDTH:0]   sh;
  logic signed [OUT_WIDTH-1:0] y_c;

  // One extra bit so the rounding bias never wraps a large positive accumulator.
  always_comb begin
    x_ext = {x[ACC_WIDTH-1], x};
    rnd   = '0;
    if (s != '0) begin
      rnd = (ACC_WIDTH + 1)'(1) << (s - 1'b1);
    end
    t   = x_ext + rnd;
    sh  = t >>> s;
    sat = 1'b0;
    y_c = sh[OUT_WIDTH-1:0];
    if (sh > HI) begin
      y_c = HI[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (sh < LO) begin
      y_c = LO[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end

`ifdef RESULT_DRAIN_RELU_EN
  assign y = y_c[OUT_WIDTH-1] ? '0 : y_c;
`else
  assign y = y_c;
`endif

endmodule

// File: rtl/result_drain_unit.sv
// Snapshots the 8x8 result on a done rising edge and streams requantized rows over valid/ready.
// Row 0 valid one cycle after capture; rows hold while stalled. Optional RESULT_DRAIN_RELU_EN.
module result_drain_unit
  import result_drain_pkg::*;
#(
  parameter int ACC_WIDTH = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT_W   = 5
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         arr_done,
  input  logic [0:ROWS-1][0:COLS-1][ACC_WIDTH-1:0]     C_in,
  input  logic [SHIFT_W-1:0]                           shift,
  output logic                                         cap_ready,
  output logic                                         row_valid,
  input  logic                                         row_ready,
  output logic [0:COLS-1][OUT_WIDTH-1:0]               row_data,
  output logic [2:0]                                   row_idx,
  output logic                                         row_last,
  output logic                                         row_sat,
  output logic                                         ovr_err
);

  drain_state_t                               state_q, state_d;
  logic                                       done_q;
  logic [2:0]                                 row_idx_q;
  logic [SHIFT_W-1:0]                         shift_q, shift_c;
  logic [0:ROWS-1][0:COLS-1][ACC_WIDTH-1:0]   mat_q;
  logic                                       cap_ev, cap_ok, hs;
  logic [COLS-1:0]                            sat_v;

  assign cap_ev = arr_done & ~done_q;
  assign cap_ok = cap_ev & (state_q == IDLE);
  assign hs     = row_valid & row_ready;

  always_comb begin
    shift_c = shift;
    if (32'(shift) > ACC_WIDTH - 1) begin
      shift_c = SHIFT_W'(ACC_WIDTH - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cap_ev) state_d = SEND;
      SEND:    if (hs && row_idx_q == 3'd7) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cap_ready = (state_q == IDLE);
    row_valid = (state_q == SEND);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      row_idx_q <= 3'd0;
      shift_q   <= '0;
      ovr_err   <= 1'b0;
    end else begin
      done_q <= arr_done;
      if (cap_ev && state_q != IDLE) begin
        ovr_err <= 1'b1;
      end
      if (cap_ok) begin
        shift_q   <= shift_c;
        row_idx_q <= 3'd0;
      end else if (hs) begin
        row_idx_q <= row_idx_q + 3'd1;
      end
    end
  end

  // Matrix storage carries no reset; it is only observable after a capture.
  always_ff @(posedge clk) begin
    if (rst_n && cap_ok) begin
      mat_q <= C_in;
    end
  end

  for (genvar g = 0; g < COLS; g++) begin : g_col
    logic [OUT_WIDTH-1:0] y_g;
    requant_sat #(
      .ACC_WIDTH (ACC_WIDTH),
      .OUT_WIDTH (OUT_WIDTH),
      .SHIFT_W   (SHIFT_W)
    ) u_rq (
      .x   (mat_q[row_idx_q][g]),
      .s   (shift_q),
      .y   (y_g),
      .sat (sat_v[g])
    );
    assign row_data[g] = row_valid ? y_g : '0;
  end

  assign row_idx  = row_idx_q;
  assign row_last = row_valid & (row_idx_q == 3'd7);
  assign row_sat  = row_valid & (|sat_v);

endmodule

// File: tb/tb_result_drain_unit.sv
// Directed bench for result_drain_unit; expectations are hand-computed per scenario.
module tb_result_drain_unit;
  import result_drain_pkg::*;

  typedef logic [0:7][0:7][31:0] mat_t;
  typedef logic [0:7][15:0]      row_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arr_done;
  mat_t        C_in;
  logic [4:0]  shift;
  logic        cap_ready;
  logic        row_valid;
  logic        row_ready;
  row_t        row_data;
  logic [2:0]  row_idx;
  logic        row_last;
  logic        row_sat;
  logic        ovr_err;

  int total = 0;
  int bad   = 0;

  result_drain_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arr_done  (arr_done),
    .C_in      (C_in),
    .shift     (shift),
    .cap_ready (cap_ready),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .row_sat   (row_sat),
    .ovr_err   (ovr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ex(int v);
`ifdef RESULT_DRAIN_RELU_EN
    if (v < 0) return 16'd0;
`endif
    return 16'(v);
  endfunction

  function automatic mat_t mk_mat(int base, int rs, int cs);
    mat_t m;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = 32'(base + r * rs + c * cs);
    return m;
  endfunction

  function automatic row_t mk_row(int base, int rs, int cs, int r);
    row_t e;
    for (int c = 0; c < 8; c++) e[c] = ex(base + r * rs + c * cs);
    return e;
  endfunction

  task automatic pulse_done();
    arr_done = 1'b1;
    @(posedge clk); #1;
    arr_done = 1'b0;
  endtask

  task automatic drain();
    row_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cap_ready) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arr_done = 1'b0; row_ready = 1'b0; C_in = '0; shift = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++; if (row_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", row_valid); end
    total++; if (cap_ready !== 1'b1) begin bad++; $display("FAIL reset_cap_ready got=%b want=1", cap_ready); end
    total++; if (row_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", row_idx); end
    total++; if (ovr_err !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", ovr_err); end
    total++; if ({row_data, row_sat, row_last} !== '0) begin bad++; $display("FAIL reset_outs got=%h/%b/%b want=0", row_data, row_sat, row_last); end
  endtask

  task automatic test_stream();
    C_in = mk_mat(0, 8, 1); shift = 5'd0; row_ready = 1'b1;
    pulse_done();
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      total++; if (row_valid !== 1'b1 || row_idx !== 3'(r)) begin bad++; $display("FAIL stream_idx r=%0d got=%b/%0d want=1/%0d", r, row_valid, row_idx, r); end
      total++; if (row_data !== mk_row(0, 8, 1, r)) begin bad++; $display("FAIL stream_data r=%0d got=%h want=%h", r, row_data, mk_row(0, 8, 1, r)); end
      total++; if (row_last !== (r == 7) || row_sat !== 1'b0 || cap_ready !== 1'b0) begin bad++; $display("FAIL stream_flags r=%0d got last=%b sat=%b cap=%b", r, row_last, row_sat, cap_ready); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++; if (cap_ready !== 1'b1 || row_valid !== 1'b0) begin bad++; $display("FAIL stream_n9 got cap=%b valid=%b want 1/0", cap_ready, row_valid); end
  endtask

  task automatic test_requant();
    row_t e;
    // shift=1: rounding, and the widened adder on 0x7FFFFFFF
    C_in = '0; C_in[0][0] = 32'(5); C_in[0][1] = 32'(-5); C_in[1][0] = 32'h7FFF_FFFF;
    shift = 5'd1; row_ready = 1'b1;
    pulse_done();
    @(negedge clk);
    e = '0; e[0] = ex(3); e[1] = ex(-2);
    total++; if (row_data !== e || row_sat !== 1'b0) begin bad++; $display("FAIL rq_round got=%h sat=%b want=%h sat=0", row_data, row_sat, e); end
    @(posedge clk); #1; @(negedge clk);
    e = '0; e[0] = ex(OUT_MAX);
    total++; if (row_data !== e || row_sat !== 1'b1) begin bad++; $display("FAIL rq_nowrap got=%h sat=%b want=%h sat=1", row_data, row_sat, e); end
    drain();
    // shift=0: saturation both ways, exact bounds do not flag
    C_in = '0; C_in[0][0] = 32'h0001_0000; C_in[0][1] = 32'(-70000);
    C_in[1][0] = 32'(OUT_MAX); C_in[1][1] = 32'(OUT_MIN); shift = 5'd0;
    pulse_done();
    @(negedge clk);
    e = '0; e[0] = ex(OUT_MAX); e[1] = ex(OUT_MIN);
    total++; if (row_data !== e || row_sat !== 1'b1) begin bad++; $display("FAIL rq_sat got=%h sat=%b want=%h sat=1", row_data, row_sat, e); end
    @(posedge clk); #1; @(negedge clk);
    total++; if (row_data !== e || row_sat !== 1'b0) begin bad++; $display("FAIL rq_bound got=%h sat=%b want=%h sat=0", row_data, row_sat, e); end
    drain();
    // shift=2: negative rounding and the optional ReLU
    C_in = '0; C_in[0][0] = 32'(-100); C_in[0][1] = 32'(100); shift = 5'd2;
    pulse_done();
    @(negedge clk);
    e = '0; e[0] = ex(-25); e[1] = ex(25);
    total++; if (row_data !== e || row_sat !== 1'b0) begin bad++; $display("FAIL rq_relu got=%h sat=%b want=%h sat=0", row_data, row_sat, e); end
    drain();
    total++; if (cap_ready !== 1'b1) begin bad++; $display("FAIL rq_drain got cap=%b want=1", cap_ready); end
  endtask

  task automatic test_backpressure();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   cnt = 0;
    logic have_prev = 1'b0, prev_rdy = 1'b0;
    logic [2:0] prev_idx = '0;
    row_t prev_dat = '0;
    C_in = mk_mat(-3000, 800, 100); shift = 5'd0; row_ready = 1'b0;
    pulse_done();
    row_ready = pat[0];
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (row_valid) begin
        if (have_prev && !prev_rdy) begin
          total++; if (row_idx !== prev_idx || row_data !== prev_dat) begin bad++; $display("FAIL bp_stable k=%0d got=%0d/%h want=%0d/%h", k, row_idx, row_data, prev_idx, prev_dat); end
        end
        if (row_ready) begin
          total++; if (row_idx !== 3'(cnt) || row_data !== mk_row(-3000, 800, 100, cnt)) begin bad++; $display("FAIL bp_order k=%0d got=%0d/%h want=%0d/%h", k, row_idx, row_data, cnt, mk_row(-3000, 800, 100, cnt)); end
          cnt++;
        end
      end
      have_prev = row_valid; prev_rdy = row_ready; prev_idx = row_idx; prev_dat = row_data;
      if (cnt == 8) break;
      @(posedge clk); #1;
      row_ready = pat[(k + 1) % 4];
    end
    @(posedge clk); #1; @(negedge clk);
    total++; if (cnt !== 8 || cap_ready !== 1'b1) begin bad++; $display("FAIL bp_count got=%0d cap=%b want=8 cap=1", cnt, cap_ready); end
  endtask

  task automatic test_overrun();
    int hs_cnt = 0;
    C_in = mk_mat(1000, 8, 1); shift = 5'd0; row_ready = 1'b1;
    arr_done = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (i == 19) arr_done = 1'b0;
      @(negedge clk);
      if (row_valid && row_ready) hs_cnt++;
    end
    total++; if (hs_cnt !== 8) begin bad++; $display("FAIL ovr_level beats got=%0d want=8", hs_cnt); end
    total++; if (ovr_err !== 1'b0 || cap_ready !== 1'b1) begin bad++; $display("FAIL ovr_level flags got ovr=%b cap=%b want 0/1", ovr_err, cap_ready); end
    row_ready = 1'b0; C_in = mk_mat(2000, 8, 1);
    pulse_done();
    C_in = mk_mat(5000, 8, 1);
    @(posedge clk); #1;
    pulse_done();
    @(negedge clk);
    total++; if (ovr_err !== 1'b1 || row_valid !== 1'b1 || row_idx !== 3'd0) begin bad++; $display("FAIL ovr_set got ovr=%b valid=%b idx=%0d want 1/1/0", ovr_err, row_valid, row_idx); end
    row_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      total++; if (row_idx !== 3'(r) || row_data !== mk_row(2000, 8, 1, r)) begin bad++; $display("FAIL ovr_data r=%0d got=%0d/%h want=%0d/%h", r, row_idx, row_data, r, mk_row(2000, 8, 1, r)); end
      @(posedge clk); #1; @(negedge clk);
    end
    total++; if (cap_ready !== 1'b1 || ovr_err !== 1'b1) begin bad++; $display("FAIL ovr_end got cap=%b ovr=%b want 1/1", cap_ready, ovr_err); end
  endtask

  task automatic test_reset_mid();
    C_in = mk_mat(3000, 8, 1); shift = 5'd0; row_ready = 1'b1;
    pulse_done();
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (row_idx !== 3'd4 || row_valid !== 1'b1) begin bad++; $display("FAIL rstm_pre got idx=%0d valid=%b want 4/1", row_idx, row_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (row_valid !== 1'b0 || cap_ready !== 1'b1 || row_idx !== 3'd0 || ovr_err !== 1'b0) begin bad++; $display("FAIL rstm_post got valid=%b cap=%b idx=%0d ovr=%b want 0/1/0/0", row_valid, cap_ready, row_idx, ovr_err); end
    C_in = mk_mat(4000, 8, 1);
    pulse_done();
    @(negedge clk);
    total++; if (row_idx !== 3'd0 || row_valid !== 1'b1 || row_data !== mk_row(4000, 8, 1, 0)) begin bad++; $display("FAIL rstm_new got=%0d/%b/%h want=0/1/%h", row_idx, row_valid, row_data, mk_row(4000, 8, 1, 0)); end
    drain();
    total++; if (cap_ready !== 1'b1) begin bad++; $display("FAIL rstm_drain got cap=%b want=1", cap_ready); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_requant();
    test_backpressure();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
